fp_norm_round: RTL and testbench

Post-add normalize-and-round stage for the single-precision pipeline. It sits directly downstream of the mantissa adder. It accepts an unnormalized sign/exponent/extended-mantissa triple and emits a packed IEEE-754 binary32 word. The stage handles carry-out, cancellation, round-to-nearest-even, overflow to infinity and flush-to-zero underflow, with status flags. It is a fixed 3-cycle pipeline with no backpressure.

---
 rtl/fp_norm_round_if.sv | 18 +
 rtl/fp_norm_round.sv | 93 +++++++++
 tb/tb_fp_norm_round.sv | 121 ++++++++++++
 3 files changed

// File: rtl/fp_norm_round_if.sv
// fp_norm_round_if: unnormalized triple in, packed binary32 word and flags out
interface fp_norm_round_if;
    logic        in_vld;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [26:0] in_mant;
    logic        out_vld;
    logic [31:0] out_data;
    logic [2:0]  out_flags;
    modport master (
        output in_vld, in_sign, in_exp, in_mant,
        input  out_vld, out_data, out_flags
    );
    modport slave (
        input  in_vld, in_sign, in_exp, in_mant,
        output out_vld, out_data, out_flags
    );
endinterface

// File: rtl/fp_norm_round.sv
// fp_norm_round: 3-stage normalize, round-to-nearest-even and pack to binary32
module fp_norm_round (
    input  logic           clk,
    input  logic           rst,
    fp_norm_round_if.slave bus
);
    logic        v1_d, v1_q, s1_d, s1_q;
    logic [7:0]  e1_d, e1_q;
    logic [26:0] m1_d, m1_q;
    logic [4:0]  lzc1_d, lzc1_q;
    logic        v2_d, v2_q, s2_d, s2_q, sp2_d, sp2_q, z2_d, z2_q;
    logic [24:0] m2_d, m2_q;
    logic [9:0]  e2_d, e2_q;
    logic        out_vld_d, out_vld_q;
    logic [31:0] out_data_d, out_data_q;
    logic [2:0]  out_flags_d, out_flags_q;
    logic        up, inx, unf, ovf;
    logic [23:0] frac;
    logic [9:0]  er;
    always_comb begin
        v1_d   = bus.in_vld;
        s1_d   = bus.in_sign;
        e1_d   = bus.in_exp;
        m1_d   = bus.in_mant;
        lzc1_d = 5'd27;
        for (int i = 0; i < 27; i++)
            if (bus.in_mant[i]) lzc1_d = 5'(26 - i);
    end
    // m2 holds only fraction, guard and sticky; the hidden bit is implied after normalization
    always_comb begin
        v2_d  = v1_q;
        s2_d  = s1_q;
        sp2_d = e1_q == 8'hFF;
        z2_d  = m1_q == 27'd0;
        m2_d  = sp2_d ? {m1_q[24:2], 2'b00} :
                m1_q[26] ? {m1_q[25:2], m1_q[1] | m1_q[0]} :
                25'(m1_q << (lzc1_q - 5'd1));
        e2_d  = m1_q[26] ? {2'b00, e1_q} + 10'd1 : {2'b00, e1_q} - {5'd0, lzc1_q} + 10'd1;
    end
    always_comb begin
        up          = m2_q[1] & (m2_q[0] | m2_q[2]);
        inx         = m2_q[1] | m2_q[0];
        frac        = {1'b0, m2_q[24:2]} + {23'd0, up};
        er          = e2_q + {9'd0, frac[23]};
        unf         = e2_q[9] | (e2_q == 10'd0);
        ovf         = !unf && er >= 10'd255;
        out_vld_d   = v2_q;
        out_data_d  = sp2_q ? {s2_q, 8'hFF, m2_q[24:2]} :
                      (z2_q | unf) ? {s2_q, 31'd0} :
                      ovf ? {s2_q, 8'hFF, 23'd0} :
                      {s2_q, er[7:0], frac[22:0]};
        out_flags_d = (sp2_q | z2_q) ? 3'b000 :
                      unf ? 3'b011 :
                      ovf ? 3'b101 :
                      {2'b00, inx};
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            v1_q        <= 1'b0;
            s1_q        <= 1'b0;
            e1_q        <= '0;
            m1_q        <= '0;
            lzc1_q      <= '0;
            v2_q        <= 1'b0;
            s2_q        <= 1'b0;
            sp2_q       <= 1'b0;
            z2_q        <= 1'b0;
            m2_q        <= '0;
            e2_q        <= '0;
            out_vld_q   <= 1'b0;
            out_data_q  <= '0;
            out_flags_q <= '0;
        end else begin
            v1_q        <= v1_d;
            s1_q        <= s1_d;
            e1_q        <= e1_d;
            m1_q        <= m1_d;
            lzc1_q      <= lzc1_d;
            v2_q        <= v2_d;
            s2_q        <= s2_d;
            sp2_q       <= sp2_d;
            z2_q        <= z2_d;
            m2_q        <= m2_d;
            e2_q        <= e2_d;
            out_vld_q   <= out_vld_d;
            out_data_q  <= out_data_d;
            out_flags_q <= out_flags_d;
        end
    end
    assign bus.out_vld   = out_vld_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_flags = out_flags_q;
endmodule

// File: tb/tb_fp_norm_round.sv
// tb_fp_norm_round: scoreboard bench with directed cases, random traffic and reset mid-stream
`timescale 1ns/1ps
module tb_fp_norm_round;
    typedef struct {
        logic [34:0] v;
        int          cyc;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    exp_t q[$];
    fp_norm_round_if bus ();
    fp_norm_round dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask
    // reference: place msb at bit 40 of a wide word, then read fraction/guard/sticky off fixed positions
    function automatic logic [34:0] model(input logic s, input logic [7:0] ex, input logic [26:0] m);
        int          p, e;
        logic [63:0] x;
        logic [23:0] f;
        logic        g, st, up;
        if (ex == 8'hFF) return {3'b000, s, 8'hFF, m[24:2]};
        if (m == 27'd0) return {3'b000, s, 31'd0};
        p = 0;
        for (int i = 0; i < 27; i++) if (m[i]) p = i;
        x  = 64'(m) << (40 - p);
        e  = int'(ex) + p - 25;
        g  = x[16];
        st = |x[15:0];
        up = g & (st | x[17]);
        f  = {1'b0, x[39:17]} + 24'(up);
        if (e <= 0) return {3'b011, s, 31'd0};
        if (f[23]) e++;
        if (e >= 255) return {3'b101, s, 8'hFF, 23'd0};
        return {2'b00, g | st, s, 8'(e), f[22:0]};
    endfunction
    task automatic drive(input logic r, input logic v, input logic s, input logic [7:0] e,
                         input logic [26:0] m, input logic [34:0] want);
        rst         = r;
        bus.in_vld  = v;
        bus.in_sign = s;
        bus.in_exp  = e;
        bus.in_mant = m;
        if (!r) q.delete();
        else if (v) q.push_back('{want, cyc + 3});
        @(posedge clk);
        #1;
        if (!r) begin
            chk("rst_vld", 64'(bus.out_vld), 64'd0);
            chk("rst_data", 64'(bus.out_data), 64'd0);
            chk("rst_flags", 64'(bus.out_flags), 64'd0);
        end
        rst        = 1'b1;
        bus.in_vld = 1'b0;
    endtask
    task automatic drive_rand(input logic r);
        logic        s;
        logic [7:0]  e;
        logic [26:0] m;
        s = 1'($urandom());
        e = 8'($urandom_range(0, 255));
        m = 27'($urandom() >> $urandom_range(5, 31));
        drive(r, 1'b1, s, e, m, model(s, e, m));
    endtask
    always @(negedge clk) begin
        if (bus.out_vld) begin
            if (q.size() == 0) begin
                chk("spurious", 64'(bus.out_vld), 64'd0);
            end else begin
                exp_t x;
                x = q.pop_front();
                chk("data", 64'(bus.out_data), 64'(x.v[31:0]));
                chk("flags", 64'(bus.out_flags), 64'(x.v[34:32]));
                chk("latency", 64'(cyc), 64'(x.cyc));
            end
        end else if (q.size() != 0 && q[0].cyc <= cyc) begin
            chk("missing", 64'(bus.out_vld), 64'd1);
            void'(q.pop_front());
        end
    end
    initial begin
        bus.in_vld  = 1'b0;
        bus.in_sign = 1'b0;
        bus.in_exp  = '0;
        bus.in_mant = '0;
        repeat (3) drive(1'b0, 1'b1, 1'b0, 8'd127, 27'h4000000, 35'd0);
        repeat (2) drive(1'b1, 1'b0, 1'b0, 8'd0, 27'd0, 35'd0);
        drive(1'b1, 1'b1, 1'b0, 8'd127, 27'h4000000, {3'b000, 32'h40000000});
        drive(1'b1, 1'b1, 1'b0, 8'd127, 27'h0000010, {3'b000, 32'h35000000});
        drive(1'b1, 1'b1, 1'b0, 8'd3,   27'h0000010, {3'b011, 32'h00000000});
        drive(1'b1, 1'b1, 1'b1, 8'd127, 27'h0000000, {3'b000, 32'h80000000});
        drive(1'b1, 1'b1, 1'b0, 8'd127, 27'h2000002, {3'b001, 32'h3F800000});
        drive(1'b1, 1'b1, 1'b0, 8'd127, 27'h2000006, {3'b001, 32'h3F800002});
        drive(1'b1, 1'b1, 1'b0, 8'd127, 27'h2000003, {3'b001, 32'h3F800001});
        drive(1'b1, 1'b1, 1'b0, 8'd127, 27'h3FFFFFE, {3'b001, 32'h40000000});
        drive(1'b1, 1'b1, 1'b1, 8'd254, 27'h7FFFFFF, {3'b101, 32'hFF800000});
        drive(1'b1, 1'b1, 1'b0, 8'd255, 27'h0000004, {3'b000, 32'h7F800001});
        repeat (5) drive(1'b1, 1'b0, 1'b0, 8'd0, 27'd0, 35'd0);
        repeat (6) drive_rand(1'b1);
        repeat (5) drive(1'b1, 1'b0, 1'b0, 8'd0, 27'd0, 35'd0);
        for (int i = 0; i < 6; i++) drive_rand(i != 2);
        repeat (5) drive(1'b1, 1'b0, 1'b0, 8'd0, 27'd0, 35'd0);
        for (int i = 0; i < 60; i++) begin
            if (i % 7 == 3) drive(1'b1, 1'b0, 1'b0, 8'd0, 27'd0, 35'd0);
            else drive_rand(1'b1);
        end
        repeat (8) drive(1'b1, 1'b0, 1'b0, 8'd0, 27'd0, 35'd0);
        chk("drain", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
